// File: rtl/mmapkron_job_sequencer_pkg.sv
// Shared types and constants for the mMapKron job sequencer.
//   seq_state_t          : sequencer FSM states
//   Pointer_QTree_*_t    : kernel pointer types (16-bit)
//   SEQ_PTR_ALL_ONES     : result pointer reported when a job times out
package mmapkron_job_sequencer_pkg;

    localparam int unsigned SEQ_NUM_OPERANDS = 2;
    localparam int unsigned SEQ_PTR_W        = 16;
    localparam int unsigned SEQ_CNT_W        = 16;

    typedef logic [SEQ_PTR_W-1:0] Pointer_QTree_Bool_t;
    typedef logic [SEQ_PTR_W-1:0] Pointer_QTree_Nat_t;

    localparam Pointer_QTree_Nat_t SEQ_PTR_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOAD = 3'd1,
        ISSUE     = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4,
        CLEAR     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/mmapkron_job_sequencer_token.sv
// One-shot valid/ready token holder.
//   arm   : pulse; raises valid on the next edge and clears sent
//   valid : token valid, held until the ready handshake
//   ready : consumer ready
//   sent  : token transferred since the last arm
module mmapkron_seq_token_issuer (
    input  logic clk,
    input  logic aresetn,
    input  logic arm,
    output logic valid,
    input  logic ready,
    output logic sent
);

    logic valid_q;
    logic sent_q;

    // Arm wins over a transfer; a token is never re-raised until re-armed.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            sent_q  <= 1'b0;
        end else if (arm) begin
            valid_q <= 1'b1;
            sent_q  <= 1'b0;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
            sent_q  <= 1'b1;
        end
    end

    assign valid = valid_q;
    assign sent  = sent_q;

endmodule

// File: rtl/mmapkron_job_sequencer.sv
// Sequences repeated mMapKron kernel invocations: waits for the operand loader,
// issues Go plus one token per operand pointer, captures the kernel result,
// hands it to the host and pulses load_clear before returning to idle.
// Ports:
//   clk, aresetn (async, active-low)
//   job_start, load_done, ld_ptr       : host request / loader status
//   load_clear                          : one-cycle loader reset pulse
//   go_valid/go_ready                   : Go token to kernel
//   op_valid/op_ready/op_data           : operand pointer tokens
//   res_valid/res_ready/res_data        : kernel result pointer
//   out_valid/out_ready/out_data        : result to host
//   busy, job_count, error              : status
// Optional feature: define JOB_TIMEOUT_EN to add the RUN-state watchdog
// (parameter TIMEOUT_CYCLES exists only in that build).
module mmapkron_job_sequencer
    import mmapkron_job_sequencer_pkg::*;
#(
    parameter int unsigned NUM_OPERANDS = SEQ_NUM_OPERANDS,
    parameter int unsigned PTR_W        = SEQ_PTR_W,
    parameter int unsigned CNT_W        = SEQ_CNT_W
`ifdef JOB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          job_start,
    input  logic                          load_done,
    input  logic [NUM_OPERANDS*PTR_W-1:0] ld_ptr,
    output logic                          load_clear,
    output logic                          go_valid,
    input  logic                          go_ready,
    output logic [NUM_OPERANDS-1:0]       op_valid,
    input  logic [NUM_OPERANDS-1:0]       op_ready,
    output logic [NUM_OPERANDS*PTR_W-1:0] op_data,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [PTR_W-1:0]              res_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PTR_W-1:0]              out_data,
    output logic                          busy,
    output logic [CNT_W-1:0]              job_count,
    output logic                          error
);

    // Token 0 is Go, tokens 1..NUM_OPERANDS are the operand pointers.
    localparam int unsigned NTOK = NUM_OPERANDS + 1;

    seq_state_t                    state_q, state_d;
    logic [NUM_OPERANDS*PTR_W-1:0] op_data_q, op_data_d;
    logic [PTR_W-1:0]              out_data_q, out_data_d;
    logic [CNT_W-1:0]              job_count_q, job_count_d;
    logic                          arm_q;
    logic                          res_ready_q;
    logic                          out_valid_q;
    logic                          load_clear_q;
    logic                          busy_q;

    logic [NTOK-1:0] tok_valid;
    logic [NTOK-1:0] tok_ready;
    logic [NTOK-1:0] tok_sent;
    logic            issue_done_c;

`ifdef JOB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] run_cnt_q;
    logic            timeout_c;
    logic            error_q, error_d;
`endif

    assign tok_ready = {op_ready, go_ready};

    // Token issuers: armed together in the first ISSUE cycle.
    for (genvar g = 0; g < NTOK; g++) begin : g_tok
        mmapkron_seq_token_issuer u_tok (
            .clk     (clk),
            .aresetn (aresetn),
            .arm     (arm_q),
            .valid   (tok_valid[g]),
            .ready   (tok_ready[g]),
            .sent    (tok_sent[g])
        );
    end

    // All tokens either already sent or transferring this edge. sent flags are
    // stale from the previous job while arm_q is high, so that cycle is masked.
    assign issue_done_c = !arm_q && (&(tok_sent | (tok_valid & tok_ready)));

`ifdef JOB_TIMEOUT_EN
    // RUN watchdog: held at zero outside RUN, so it restarts on every RUN entry.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run_cnt_q <= '0;
        end else if (state_q != RUN) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = (state_q == RUN) && (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        op_data_d   = op_data_q;
        out_data_d  = out_data_q;
        job_count_d = job_count_q;
`ifdef JOB_TIMEOUT_EN
        error_d     = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    state_d = WAIT_LOAD;
`ifdef JOB_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            WAIT_LOAD: begin
                if (load_done) begin
                    state_d   = ISSUE;
                    op_data_d = ld_ptr;
                end
            end
            ISSUE: begin
                if (issue_done_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (res_valid && res_ready_q) begin
                    state_d    = DONE;
                    out_data_d = res_data;
                end
`ifdef JOB_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d    = DONE;
                    out_data_d = '1;
                    error_d    = 1'b1;
                end
`endif
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = CLEAR;
                    job_count_d = job_count_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and state-decoded output registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            op_data_q    <= '0;
            out_data_q   <= '0;
            job_count_q  <= '0;
            arm_q        <= 1'b0;
            res_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            load_clear_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_data_q    <= op_data_d;
            out_data_q   <= out_data_d;
            job_count_q  <= job_count_d;
            arm_q        <= (state_q == WAIT_LOAD) && load_done;
            res_ready_q  <= (state_d == RUN);
            out_valid_q  <= (state_d == DONE);
            load_clear_q <= (state_d == CLEAR);
            busy_q       <= (state_d != IDLE);
        end
    end

`ifdef JOB_TIMEOUT_EN
    // Sticky watchdog flag, cleared only when a new job is accepted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign go_valid   = tok_valid[0];
    assign op_valid   = tok_valid[NTOK-1:1];
    assign op_data    = op_data_q;
    assign res_ready  = res_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign load_clear = load_clear_q;
    assign busy       = busy_q;
    assign job_count  = job_count_q;

endmodule

// File: tb/tb_mmapkron_job_sequencer.sv
module tb_mmapkron_job_sequencer;
    import mmapkron_job_sequencer_pkg::*;

    localparam int unsigned NOP = 2;
    localparam int unsigned PW  = 16;
    localparam int unsigned CW  = 4;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              job_start;
    logic              load_done;
    logic [NOP*PW-1:0] ld_ptr;
    logic              load_clear;
    logic              go_valid;
    logic              go_ready;
    logic [NOP-1:0]    op_valid;
    logic [NOP-1:0]    op_ready;
    logic [NOP*PW-1:0] op_data;
    logic              res_valid;
    logic              res_ready;
    logic [PW-1:0]     res_data;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_data;
    logic              busy;
    logic [CW-1:0]     job_count;
    logic              error;

    int errors = 0;
    int checks = 0;

    int go_x = 0, op0_x = 0, op1_x = 0, res_x = 0, lc_n = 0;

    always #5 clk = ~clk;

    mmapkron_job_sequencer #(
        .NUM_OPERANDS (NOP),
        .PTR_W        (PW),
        .CNT_W        (CW)
`ifdef JOB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .job_start  (job_start),
        .load_done  (load_done),
        .ld_ptr     (ld_ptr),
        .load_clear (load_clear),
        .go_valid   (go_valid),
        .go_ready   (go_ready),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .job_count  (job_count),
        .error      (error)
    );

    // Handshake / pulse counters, sampled mid-cycle where everything is stable.
    always @(negedge clk) begin
        if (aresetn) begin
            if (go_valid && go_ready)         go_x++;
            if (op_valid[0] && op_ready[0])   op0_x++;
            if (op_valid[1] && op_ready[1])   op1_x++;
            if (res_valid && res_ready)       res_x++;
            if (load_clear)                   lc_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: runs one job with everything ready; ok=0 if it never finishes.
    task automatic run_job(input logic [PW-1:0] r, output bit ok);
        ok = 1'b0;
        go_ready = 1'b1; op_ready = '1; out_ready = 1'b1;
        res_valid = 1'b1; res_data = r; load_done = 1'b1; job_start = 1'b1;
        tick();
        job_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        load_done = 1'b0; res_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; job_start = 0; load_done = 0; ld_ptr = '0;
        go_ready = 0; op_ready = '0; res_valid = 0; res_data = '0; out_ready = 0;
        #3;
        checks++; if ({load_clear, go_valid, op_valid, res_ready, out_valid, busy, error} !== 8'd0) begin
            errors++; $display("FAIL rst_ctrl: got %b want 00000000", {load_clear, go_valid, op_valid, res_ready, out_valid, busy, error}); end
        checks++; if ({op_data, out_data, job_count} !== '0) begin
            errors++; $display("FAIL rst_data: op_data=%h out_data=%h job_count=%0d want 0", op_data, out_data, job_count); end
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_single_job();
        int g0 = go_x, a0 = op0_x, b0 = op1_x, l0 = lc_n;
        go_ready = 1; op_ready = 2'b11; out_ready = 1; res_valid = 0; load_done = 0;
        ld_ptr = {16'h0011, 16'h0022}; job_start = 1;
        tick(); job_start = 0;
        checks++; if (busy !== 1'b1 || go_valid !== 1'b0) begin errors++; $display("FAIL s1_wait: busy=%b go_valid=%b want 1 0", busy, go_valid); end
        load_done = 1;
        tick(); load_done = 0;
        checks++; if (op_data !== 32'h0011_0022) begin errors++; $display("FAIL s1_capture: op_data=%h want 00110022", op_data); end
        checks++; if (go_valid !== 1'b0) begin errors++; $display("FAIL s1_go_latency: go_valid=%b want 0", go_valid); end
        tick();
        checks++; if ({go_valid, op_valid} !== 3'b111 || res_ready !== 1'b0) begin
            errors++; $display("FAIL s1_tokens: go/op=%b res_ready=%b want 111 0", {go_valid, op_valid}, res_ready); end
        tick();
        checks++; if ({go_valid, op_valid} !== 3'b000 || res_ready !== 1'b1) begin
            errors++; $display("FAIL s1_run: go/op=%b res_ready=%b want 000 1", {go_valid, op_valid}, res_ready); end
        res_valid = 1; res_data = 16'h0abc;
        tick(); res_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0abc || job_count !== 4'd0) begin
            errors++; $display("FAIL s1_out: out_valid=%b out_data=%h job_count=%0d want 1 0abc 0", out_valid, out_data, job_count); end
        tick();
        checks++; if (job_count !== 4'd1 || load_clear !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL s1_clear: job_count=%0d load_clear=%b out_valid=%b want 1 1 0", job_count, load_clear, out_valid); end
        tick();
        checks++; if (load_clear !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL s1_idle: load_clear=%b busy=%b want 0 0", load_clear, busy); end
        checks++; if (go_x - g0 != 1 || op0_x - a0 != 1 || op1_x - b0 != 1 || lc_n - l0 != 1) begin
            errors++; $display("FAIL s1_counts: go=%0d op0=%0d op1=%0d clr=%0d want 1 each", go_x - g0, op0_x - a0, op1_x - b0, lc_n - l0); end
    endtask

    task automatic test_staggered();
        int g0 = go_x, a0 = op0_x, b0 = op1_x;
        logic [3:0] exp;
        ld_ptr = {16'h1234, 16'h5678}; go_ready = 0; op_ready = 2'b10; res_valid = 0; out_ready = 1;
        job_start = 1;
        tick(); job_start = 0; load_done = 1;
        tick(); load_done = 0;
        tick();
        for (int k = 0; k <= 6; k++) begin
            op_ready = {1'b1, 1'(k >= 3)};
            go_ready = 1'(k >= 5);
            exp = {1'(k <= 5), 1'(k == 0), 1'(k <= 3), 1'(k == 6)};
            checks++; if ({go_valid, op_valid, res_ready} !== exp) begin
                errors++; $display("FAIL st_valids k=%0d: go/op1/op0/res_ready=%b want %b", k, {go_valid, op_valid, res_ready}, exp); end
            checks++; if (op_data !== 32'h1234_5678) begin
                errors++; $display("FAIL st_data k=%0d: op_data=%h want 12345678", k, op_data); end
            tick();
        end
        res_valid = 1; res_data = 16'h4321;
        tick(); res_valid = 0;
        tick(); tick();
        checks++; if (go_x - g0 != 1 || op0_x - a0 != 1 || op1_x - b0 != 1) begin
            errors++; $display("FAIL st_no_dup: go=%0d op0=%0d op1=%0d want 1 each", go_x - g0, op0_x - a0, op1_x - b0); end
        checks++; if (job_count !== 4'd2 || out_data !== 16'h4321 || busy !== 1'b0) begin
            errors++; $display("FAIL st_done: job_count=%0d out_data=%h busy=%b want 2 4321 0", job_count, out_data, busy); end
    endtask

    task automatic test_early_result();
        int r0 = res_x;
        ld_ptr = 32'h0a0a_0b0b; res_valid = 1; res_data = 16'hbeef;
        go_ready = 0; op_ready = 2'b11; out_ready = 0; job_start = 1;
        tick(); job_start = 0;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL er_wait: res_ready=%b want 0", res_ready); end
        load_done = 1;
        tick(); load_done = 0;
        tick();
        checks++; if (res_ready !== 1'b0 || go_valid !== 1'b1) begin
            errors++; $display("FAIL er_issue: res_ready=%b go_valid=%b want 0 1", res_ready, go_valid); end
        go_ready = 1;
        tick();
        checks++; if (res_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL er_run: res_ready=%b out_valid=%b want 1 0", res_ready, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hbeef || res_ready !== 1'b0) begin
            errors++; $display("FAIL er_capture: out_valid=%b out_data=%h res_ready=%b want 1 beef 0", out_valid, out_data, res_ready); end
        res_data = 16'h1111;
        tick();
        checks++; if (out_data !== 16'hbeef || res_x - r0 != 1) begin
            errors++; $display("FAIL er_once: out_data=%h res_xfers=%0d want beef 1", out_data, res_x - r0); end
        out_ready = 1;
        tick(); res_valid = 0;
        tick();
        checks++; if (job_count !== 4'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL er_end: job_count=%0d busy=%b want 3 0", job_count, busy); end
    endtask

    task automatic test_backpressure();
        ld_ptr = 32'hcafe_f00d; go_ready = 1; op_ready = 2'b11; out_ready = 0;
        res_valid = 1; res_data = 16'h5a5a; job_start = 1;
        tick(); job_start = 0; load_done = 1;
        tick(); load_done = 0;
        tick(); tick(); tick();
        res_valid = 0;
        for (int i = 0; i < 10; i++) begin
            job_start = 1'(i == 3);
            checks++; if (out_valid !== 1'b1 || out_data !== 16'h5a5a || job_count !== 4'd3 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold i=%0d: out_valid=%b out_data=%h job_count=%0d busy=%b want 1 5a5a 3 1", i, out_valid, out_data, job_count, busy); end
            tick();
        end
        job_start = 0; out_ready = 1;
        tick();
        checks++; if (job_count !== 4'd4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_count: job_count=%0d out_valid=%b want 4 0", job_count, out_valid); end
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_not_queued: busy=%b want 0", busy); end
    endtask

    task automatic test_load_done_early();
        ld_ptr = 32'h0f0f_a5a5; go_ready = 1; op_ready = 2'b11; out_ready = 1; res_valid = 0;
        load_done = 1; job_start = 1;
        tick(); job_start = 0;
        checks++; if (busy !== 1'b1 || op_data !== 32'hcafe_f00d) begin
            errors++; $display("FAIL ld_wait: busy=%b op_data=%h want 1 cafef00d", busy, op_data); end
        tick();
        checks++; if (op_data !== 32'h0f0f_a5a5 || go_valid !== 1'b0) begin
            errors++; $display("FAIL ld_capture: op_data=%h go_valid=%b want 0f0fa5a5 0", op_data, go_valid); end
        tick(); load_done = 0;
        checks++; if ({go_valid, op_valid} !== 3'b111) begin
            errors++; $display("FAIL ld_issue: go/op=%b want 111", {go_valid, op_valid}); end
        tick(); res_valid = 1; res_data = 16'h0077;
        tick(); res_valid = 0;
        tick(); tick();
        checks++; if (job_count !== 4'd5 || out_data !== 16'h0077 || busy !== 1'b0) begin
            errors++; $display("FAIL ld_end: job_count=%0d out_data=%h busy=%b want 5 0077 0", job_count, out_data, busy); end
    endtask

    task automatic test_reset_mid_run();
        int l0;
        ld_ptr = 32'h1357_9bdf; go_ready = 1; op_ready = 2'b11; out_ready = 1; res_valid = 0;
        job_start = 1;
        tick(); job_start = 0; load_done = 1;
        tick(); load_done = 0;
        tick(); tick();
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rr_in_run: res_ready=%b want 1", res_ready); end
        l0 = lc_n;
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({load_clear, go_valid, op_valid, res_ready, out_valid, busy, error} !== 8'd0) begin
            errors++; $display("FAIL rr_ctrl: got %b want 00000000", {load_clear, go_valid, op_valid, res_ready, out_valid, busy, error}); end
        checks++; if ({op_data, out_data, job_count} !== '0) begin
            errors++; $display("FAIL rr_data: op_data=%h out_data=%h job_count=%0d want 0", op_data, out_data, job_count); end
        @(posedge clk); #1 aresetn = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0 || lc_n != l0) begin
            errors++; $display("FAIL rr_no_clear: busy=%b load_clear_pulses=%0d want 0 0", busy, lc_n - l0); end
    endtask

    task automatic test_count_wrap();
        bit ok;
        bit all_ok = 1'b1;
        for (int j = 0; j < 15; j++) begin
            run_job(16'(j), ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || job_count !== 4'd15) begin
            errors++; $display("FAIL wrap_15: finished=%b job_count=%0d want 1 15", all_ok, job_count); end
        run_job(16'h0f00, ok);
        checks++; if (!ok || job_count !== 4'd0 || out_data !== 16'h0f00) begin
            errors++; $display("FAIL wrap_0: finished=%b job_count=%0d out_data=%h want 1 0 0f00", ok, job_count, out_data); end
    endtask

`ifdef JOB_TIMEOUT_EN
    task automatic test_timeout();
        go_ready = 1; op_ready = 2'b11; out_ready = 0; res_valid = 0; job_start = 1;
        tick(); job_start = 0; load_done = 1;
        tick(); load_done = 0;
        tick(); tick();
        for (int r = 0; r < 8; r++) begin
            checks++; if (res_ready !== 1'b1 || error !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL to_run r=%0d: res_ready=%b error=%b out_valid=%b want 1 0 0", r, res_ready, error, out_valid); end
            tick();
        end
        checks++; if (error !== 1'b1 || out_valid !== 1'b1 || out_data !== SEQ_PTR_ALL_ONES) begin
            errors++; $display("FAIL to_fire: error=%b out_valid=%b out_data=%h want 1 1 ffff", error, out_valid, out_data); end
        out_ready = 1;
        tick();
        tick();
        checks++; if (job_count !== 4'd1 || error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_sticky: job_count=%0d error=%b busy=%b want 1 1 0", job_count, error, busy); end
        job_start = 1;
        tick(); job_start = 0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_clear: error=%b want 0", error); end
        aresetn = 1'b0;
        tick(); aresetn = 1'b1;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        go_ready = 1; op_ready = 2'b11; out_ready = 1; res_valid = 0; job_start = 1;
        tick(); job_start = 0; load_done = 1;
        tick(); load_done = 0;
        tick(); tick();
        repeat (20) tick();
        checks++; if (res_ready !== 1'b1 || error !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL nt_wait: res_ready=%b error=%b out_valid=%b want 1 0 0", res_ready, error, out_valid); end
        res_valid = 1; res_data = 16'h2468;
        tick(); res_valid = 0;
        tick(); tick();
        checks++; if (job_count !== 4'd1 || out_data !== 16'h2468 || busy !== 1'b0) begin
            errors++; $display("FAIL nt_end: job_count=%0d out_data=%h busy=%b want 1 2468 0", job_count, out_data, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_staggered();
        test_early_result();
        test_backpressure();
        test_load_done_early();
        test_reset_mid_run();
        test_count_wrap();
`ifdef JOB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
